// File: rtl/simple_bus_arbiter_pkg.sv
// Shared types for the common-bus arbiter: FSM state and source bit positions.
// Ports: none (package only).
package simple_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int SRC_PC = 0;
  localparam int SRC_AR = 1;
  localparam int SRC_DR = 2;
  localparam int SRC_AC = 3;

endpackage

// File: rtl/simple_bus_arbiter_if.sv
// Arbiter <-> bus sources bundle: requests in, one-hot read enables out.
// master: arbiter side (drives grant/bus_sel/busy/turnaround); slave: sources.
interface simple_bus_arbiter_if #(
  parameter int NREQ = 4
) ();
  localparam int SW = $clog2(NREQ);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic [SW-1:0]   bus_sel;
  logic            busy;
  logic            turnaround;

  modport master (
    input  req,
    output grant,
    output bus_sel,
    output busy,
    output turnaround
  );

  modport slave (
    output req,
    input  grant,
    input  bus_sel,
    input  busy,
    input  turnaround
  );
endinterface

// File: rtl/simple_bus_arbiter_rr_pick.sv
// Round-robin picker: first set req bit at or after rr_ptr, with wrap.
// Ports: req, rr_ptr in; found, idx out. Purely combinational.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] idx
);
  localparam int IW = $clog2(NREQ);

  int pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(rr_ptr) + k) % NREQ;
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = IW'(pos);
      end
    end
  end
endmodule

// File: rtl/simple_bus_arbiter.sv
// Round-robin owner of the common tri-state bus with bounded hold time
// and a forced one-cycle all-Z turnaround. Ports: clk, rst_n, bus (master).
module simple_bus_arbiter
  import simple_bus_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  simple_bus_arbiter_if.master bus
);
  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  state_t          state;
  logic [NREQ-1:0] grant_q;
  logic [IW-1:0]   sel_q;
  logic            busy_q;
  logic            ta_q;
  logic [IW-1:0]   rr_ptr;
  logic [HW-1:0]   hold_cnt;

  logic            found;
  logic [IW-1:0]   idx;
  logic [NREQ-1:0] pick_oh;
  logic            others;
  logic            owner_req;
  logic            hold_full;
  logic [IW-1:0]   nxt_ptr;

  rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req   (bus.req),
    .rr_ptr(rr_ptr),
    .found (found),
    .idx   (idx)
  );

  assign pick_oh   = NREQ'(1) << idx;
  assign others    = |(bus.req & ~grant_q);
  assign owner_req = bus.req[sel_q];
  assign hold_full = (hold_cnt == HOLD_MAX);
  assign nxt_ptr   = (sel_q == IW'(NREQ - 1)) ? '0 : sel_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_q  <= '0;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      ta_q     <= 1'b0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
    end else begin
      unique case (state)
        IDLE, GAP: begin
          ta_q <= 1'b0;
          if (found) begin
            state    <= OWN;
            grant_q  <= pick_oh;
            sel_q    <= idx;
            busy_q   <= 1'b1;
            hold_cnt <= HW'(1);
          end else begin
            state   <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        OWN: begin
          // Owner leaves voluntarily or is evicted once its
          // hold budget is spent and someone else is waiting.
          if (!owner_req || (hold_full && others)) begin
            state   <= GAP;
            grant_q <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            ta_q    <= 1'b1;
            rr_ptr  <= nxt_ptr;
          end else if (!hold_full) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          sel_q   <= '0;
          busy_q  <= 1'b0;
          ta_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.bus_sel    = sel_q;
  assign bus.busy       = busy_q;
  assign bus.turnaround = ta_q;
endmodule

// File: tb/tb_simple_bus_arbiter.sv
// Directed bench for simple_bus_arbiter with a cycle model feeding a
// scoreboard queue; outputs are checked #1 after every rising edge.
module tb_simple_bus_arbiter;
  import simple_bus_pkg::*;

  localparam int N  = 4;
  localparam int MH = 8;

  typedef struct {
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
    logic       t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  simple_bus_arbiter_if #(.NREQ(N)) bus ();

  simple_bus_arbiter #(
    .NREQ    (N),
    .MAX_HOLD(MH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  exp_t sbq[$];

  // reference model state
  int m_st = 0;
  int m_own = 0;
  int m_ptr = 0;
  int m_hold = 0;
  logic [3:0] prev_g = '0;
  int ta_seen = 0;
  int owners[$];

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t",
             tag, obs, exp, $time);
    end
  endtask

  task automatic model(input logic rn, input logic [3:0] r);
    exp_t e;
    bit hit;
    int j;
    if (!rn) begin
      m_st = 0; m_ptr = 0; m_hold = 0; m_own = 0;
    end else if (m_st == 1) begin
      if (!r[m_own] ||
          (m_hold == MH && (r & ~(4'b1 << m_own)) != 4'b0)) begin
        m_st = 2;
        m_ptr = (m_own + 1) % N;
      end else if (m_hold < MH) begin
        m_hold++;
      end
    end else begin
      hit = 0;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (!hit && r[j]) begin
          hit = 1; m_own = j;
        end
      end
      m_st = hit ? 1 : 0;
      if (hit) m_hold = 1;
    end
    e.g = (m_st == 1) ? (4'b1 << m_own) : 4'b0;
    e.s = (m_st == 1) ? 2'(m_own) : 2'd0;
    e.b = (m_st == 1);
    e.t = (m_st == 2);
    sbq.push_back(e);
  endtask

  task automatic step(input logic rn, input logic [3:0] r);
    exp_t e;
    rst_n   = rn;
    bus.req = r;
    model(rn, r);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("grant", 8'(bus.grant), 8'(e.g));
    chk("bus_sel", 8'(bus.bus_sel), 8'(e.s));
    chk("busy", 8'(bus.busy), 8'(e.b));
    chk("turnaround", 8'(bus.turnaround), 8'(e.t));
    chk("onehot0", 8'($onehot0(bus.grant)), 8'd1);
    chk("busy_eq_or", 8'(bus.busy), 8'(|bus.grant));
    if (bus.grant != 4'b0 && prev_g != 4'b0)
      chk("no_overlap", 8'(bus.grant), 8'(prev_g));
    if (bus.turnaround) ta_seen++;
    if (bus.grant != 4'b0 && bus.grant != prev_g)
      owners.push_back(int'(bus.bus_sel));
    prev_g = bus.grant;
  endtask

  task automatic run(input int n, input logic rn, input logic [3:0] r);
    for (int i = 0; i < n; i++) step(rn, r);
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.req = '0;

    // reset then single request from DR
    run(2, 1'b0, 4'b0100);
    chk("reset_grant", 8'(bus.grant), 8'h00);
    run(1, 1'b1, 4'b0100);
    chk("dr_grant", 8'(bus.grant), 8'h04);
    chk("dr_sel", 8'(bus.bus_sel), 8'(SRC_DR));
    run(4, 1'b1, 4'b0100);
    chk("dr_held", 8'(bus.grant), 8'h04);

    // release to PC through one turnaround cycle
    run(1, 1'b1, 4'b0001);
    chk("gap_grant", 8'(bus.grant), 8'h00);
    chk("gap_ta", 8'(bus.turnaround), 8'h01);
    run(1, 1'b1, 4'b0001);
    chk("pc_grant", 8'(bus.grant), 8'h01);

    // round robin under full contention
    run(1, 1'b0, 4'b0000);
    owners.delete();
    run(40, 1'b1, 4'b1111);
    chk("rr_count", 8'(owners.size()), 8'd5);
    for (int i = 0; i < 5 && i < owners.size(); i++)
      chk($sformatf("rr_owner%0d", i), 8'(owners[i]), 8'(i % N));

    // no contention: AR keeps the bus past the hold limit
    run(1, 1'b0, 4'b0000);
    run(1, 1'b1, 4'b0010);
    ta_seen = 0;
    run(20, 1'b1, 4'b0010);
    chk("nc_grant", 8'(bus.grant), 8'h02);
    chk("nc_no_gap", 8'(ta_seen), 8'd0);

    // reset while AC owns the bus
    run(1, 1'b0, 4'b0000);
    run(3, 1'b1, 4'b1000);
    chk("ac_grant", 8'(bus.grant), 8'h08);
    run(1, 1'b0, 4'b1000);
    chk("midrst_grant", 8'(bus.grant), 8'h00);
    chk("midrst_busy", 8'(bus.busy), 8'h00);
    run(1, 1'b1, 4'b1001);
    chk("post_rst_win", 8'(bus.grant), 8'h01);

    // previous owner re-requests but yields to the waiter
    run(1, 1'b0, 4'b0000);
    run(2, 1'b1, 4'b0010);
    chk("ar_owner", 8'(bus.grant), 8'h02);
    run(1, 1'b1, 4'b1000);
    chk("ar_gap", 8'(bus.turnaround), 8'h01);
    run(1, 1'b1, 4'b1010);
    chk("ac_first", 8'(bus.grant), 8'h08);
    run(3, 1'b1, 4'b1010);
    run(1, 1'b1, 4'b0010);
    chk("ac_gap", 8'(bus.turnaround), 8'h01);
    run(1, 1'b1, 4'b0010);
    chk("ar_second", 8'(bus.grant), 8'h02);

    run(2, 1'b1, 4'b0000);
    chk("idle_sel", 8'(bus.bus_sel), 8'h00);
    chk("sb_empty", 8'(sbq.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
